echo_cancel_seq: RTL and testbench
==================================

ECHO_CANCEL_SEQ -- requirements
Module: echo_cancel_seq

Interface
REQ-001 Parameter CNT_W, 13, width of sampling_cycle_counter.
REQ-002 Parameter DATA_W, 64, width of IEEE-754 double data paths.
REQ-003 Parameter ITER_W, 16, width of iteration counter.
REQ-004 Parameter TRAIN_SAMPLES, 100, number of completed samples spent in adaptation before auto switch to cancel-only.
REQ-005 Parameter TIMEOUT, 4095, max clk_operation cycles spent waiting on any one ready (>=1).
REQ-006 Ports: clk_operation in 1, sole clock; rst in 1, asynchronous active-low reset (asserted at 0); one clock, reset asynchronous and active-low.
REQ-007 enable in 1 gates new sample ticks; sampling_cycle_counter in CNT_W; mode in 2 (00 auto, 01 force train, 10 force cancel, 11 freeze).
REQ-008 conv_start out 1, conv_ready in 1 (both converters ANDed externally); adapt_start out 1, adapt_ready in 1; cancel_start out 1, cancel_ready in 1.
REQ-009 e in DATA_W (adaptation error); swe in DATA_W (signal without echo); out_double out DATA_W; out_start out 1.
REQ-010 training out 1; iteration out ITER_W; busy out 1; overrun out 1; timeout out 1; clear_flags in 1.

Function
REQ-011 Tick SHALL be one cycle: enable=1, sampling_cycle_counter==0, and counter was nonzero on previous cycle (first zero after reset counts).
REQ-012 FSM states IDLE, CONV, ADAPT, CANCEL, OUTPUT; busy=1 in every state except IDLE.
REQ-013 IDLE: on tick with mode!=11, latch mode, go CONV; mode 11 ignores tick, no starts issued.
REQ-014 Each xxx_start SHALL be a one-cycle pulse in the first cycle of its state; ready sampled from the following cycle onward (level-sensitive).
REQ-015 Path select at tick: train if mode 01, or mode 00 and train_cnt<TRAIN_SAMPLES; else cancel.
REQ-016 Train path CONV->ADAPT->CANCEL->OUTPUT; cancel path CONV->CANCEL->OUTPUT; advance on ready=1.
REQ-017 OUTPUT (one cycle): register out_double = e (train) or swe (cancel), pulse out_start same cycle out_double updates, return IDLE.
REQ-018 iteration increments on each OUTPUT, saturating at all-ones; train_cnt increments on train-path OUTPUT, saturating at TRAIN_SAMPLES.
REQ-019 training output = 1 when the next tick would select train path.
REQ-020 Watchdog: counter cleared on state entry; if TIMEOUT cycles elapse in CONV/ADAPT/CANCEL without ready, set timeout, return IDLE, no OUTPUT, counters unchanged.
REQ-021 Tick while busy: set overrun, tick dropped, current sample unaffected.
REQ-022 overrun/timeout sticky until clear_flags=1; set in same cycle as clear SHALL win.
REQ-023 enable or mode change mid-sample SHALL not affect the sample in progress.
REQ-024 Minimum latency tick->out_start: cancel path 5 cycles, train path 7 cycles, with ready returned the cycle after each start.

Reset
REQ-025 rst=0 SHALL immediately force IDLE; all starts 0, out_double 0, iteration 0, train_cnt 0, overrun 0, timeout 0, busy 0; training 1 after release (mode 00).
REQ-026 Reset mid-sample abandons the sample with no out_start; first tick after release accepted.

Structure
REQ-027 Package echo_seq_pkg SHALL hold state enum, mode encodings (MODE_AUTO/TRAIN/CANCEL/FREEZE), DOUBLE_W=64.
REQ-028 One sub-module seq_watchdog (clear, count, expire at TIMEOUT) instantiated once.

Verification
REQ-029 Auto mode, TRAIN_SAMPLES=3, readies 1 cycle after each start: 3 train outputs out_double=e, then swe; training falls after 3rd OUTPUT; iteration=4 after 4 ticks.
REQ-030 cancel_ready held 0, TIMEOUT=10: timeout=1 exactly 10 cycles after CANCEL entry, no out_start, iteration unchanged; clear_flags clears it.
REQ-031 Second tick during ADAPT: overrun=1, only one out_start for first sample.
REQ-032 rst=0 during CANCEL: outputs at reset values same edge-free time, no out_start; next tick runs normally.
REQ-033 mode 11 with ticks: no start pulses; mode 10 at train_cnt=0: cancel path, out_double=swe.
REQ-034 counter held at 0 for 5 cycles: single tick; iteration 0xFFFF plus one OUTPUT stays 0xFFFF.

Source files
------------

// File: rtl/echo_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : echo_seq_pkg
// Purpose  : Shared state encoding, mode codes and data width for the echo
//            cancellation sequencer.
// Revision : 1.0
// ============================================================================
package echo_seq_pkg;

   localparam int DOUBLE_W = 64;

   localparam logic [1:0] MODE_AUTO   = 2'b00;
   localparam logic [1:0] MODE_TRAIN  = 2'b01;
   localparam logic [1:0] MODE_CANCEL = 2'b10;
   localparam logic [1:0] MODE_FREEZE = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CONV   = 3'd1,
      ST_ADAPT  = 3'd2,
      ST_CANCEL = 3'd3,
      ST_OUTPUT = 3'd4
   } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/seq_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : seq_watchdog
// Purpose  : Cycle counter that is cleared on state entry and flags expiry
//            once TIMEOUT cycles have been spent waiting.
// Revision : 1.0
// ============================================================================
module seq_watchdog
   import echo_seq_pkg::*;
#(
   parameter int TIMEOUT = 4095
) (
   input  logic clk_operation,
   input  logic rst,
   input  logic clear,
   input  logic count_en,
   output logic expired
);

   localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [WD_W-1:0] c_last = WD_W'(TIMEOUT - 1);

   logic [WD_W-1:0] r_cnt;

   always_ff @(posedge clk_operation or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if (clear) begin
         r_cnt <= '0;
      end else if (count_en && (r_cnt != c_last)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // The entry cycle counts as the first waited cycle.
   assign expired = count_en && (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/echo_cancel_seq.sv
`default_nettype none
// ============================================================================
// Module   : echo_cancel_seq
// Purpose  : Per-sample sequencer driving converter, adaptation and
//            cancellation engines, with training/cancel path selection.
// Revision : 1.0
// ============================================================================
module echo_cancel_seq
   import echo_seq_pkg::*;
#(
   parameter int CNT_W         = 13,
   parameter int DATA_W        = DOUBLE_W,
   parameter int ITER_W        = 16,
   parameter int TRAIN_SAMPLES = 100,
   parameter int TIMEOUT       = 4095
) (
   input  logic              clk_operation,
   input  logic              rst,
   input  logic              enable,
   input  logic [CNT_W-1:0]  sampling_cycle_counter,
   input  logic [1:0]        mode,
   output logic              conv_start,
   input  logic              conv_ready,
   output logic              adapt_start,
   input  logic              adapt_ready,
   output logic              cancel_start,
   input  logic              cancel_ready,
   input  logic [DATA_W-1:0] e,
   input  logic [DATA_W-1:0] swe,
   output logic [DATA_W-1:0] out_double,
   output logic              out_start,
   output logic              training,
   output logic [ITER_W-1:0] iteration,
   output logic              busy,
   output logic              overrun,
   output logic              timeout,
   input  logic              clear_flags
);

   localparam int TC_W = (TRAIN_SAMPLES < 1) ? 1 : $clog2(TRAIN_SAMPLES + 1);
   localparam logic [TC_W-1:0] c_train_max = TC_W'(TRAIN_SAMPLES);

   seq_state_t        r_state;
   seq_state_t        w_next;
   logic              r_entry;
   logic              r_cnt_nz_prev;
   logic              r_path_train;
   logic [TC_W-1:0]   r_train_cnt;
   logic [ITER_W-1:0] r_iteration;
   logic [DATA_W-1:0] r_out_double;
   logic              r_overrun;
   logic              r_timeout;

   logic w_tick;
   logic w_train_sel;
   logic w_wait;
   logic w_ready;
   logic w_expired;
   logic w_state_change;
   logic w_accept;
   logic w_enter_output;
   logic w_timeout_set;
   logic w_overrun_set;

   // Reset value of r_cnt_nz_prev lets the first zero after reset tick.
   assign w_tick      = enable && (sampling_cycle_counter == '0) && r_cnt_nz_prev;
   assign w_train_sel = (mode == MODE_TRAIN) ||
                        ((mode == MODE_AUTO) && (r_train_cnt < c_train_max));

   assign w_wait  = (r_state == ST_CONV) || (r_state == ST_ADAPT) ||
                    (r_state == ST_CANCEL);
   assign w_ready = !r_entry &&
                    (((r_state == ST_CONV)   && conv_ready)  ||
                     ((r_state == ST_ADAPT)  && adapt_ready) ||
                     ((r_state == ST_CANCEL) && cancel_ready));

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         ST_IDLE: begin
            if (w_tick && (mode != MODE_FREEZE)) w_next = ST_CONV;
         end
         ST_CONV: begin
            if (w_ready)        w_next = r_path_train ? ST_ADAPT : ST_CANCEL;
            else if (w_expired) w_next = ST_IDLE;
         end
         ST_ADAPT: begin
            if (w_ready)        w_next = ST_CANCEL;
            else if (w_expired) w_next = ST_IDLE;
         end
         ST_CANCEL: begin
            if (w_ready)        w_next = ST_OUTPUT;
            else if (w_expired) w_next = ST_IDLE;
         end
         ST_OUTPUT: w_next = ST_IDLE;
         default:   w_next = ST_IDLE;
      endcase
   end

   assign w_state_change = (w_next != r_state);
   assign w_accept       = (r_state == ST_IDLE) && w_tick && (mode != MODE_FREEZE);
   assign w_enter_output = (r_state == ST_CANCEL) && w_ready;
   assign w_timeout_set  = w_wait && !w_ready && w_expired;
   assign w_overrun_set  = w_tick && (r_state != ST_IDLE);

   seq_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk_operation (clk_operation),
      .rst           (rst),
      .clear         (w_state_change),
      .count_en      (w_wait),
      .expired       (w_expired)
   );

   always_ff @(posedge clk_operation or negedge rst) begin
      if (!rst) begin
         r_state       <= ST_IDLE;
         r_entry       <= 1'b0;
         r_cnt_nz_prev <= 1'b1;
         r_path_train  <= 1'b0;
         r_train_cnt   <= '0;
         r_iteration   <= '0;
         r_out_double  <= '0;
         r_overrun     <= 1'b0;
         r_timeout     <= 1'b0;
      end else begin
         r_state       <= w_next;
         r_entry       <= w_state_change;
         r_cnt_nz_prev <= |sampling_cycle_counter;

         if (w_accept) r_path_train <= w_train_sel;

         // Result and counters land on the edge into OUTPUT so out_start
         // and the new out_double appear together.
         if (w_enter_output) begin
            r_out_double <= r_path_train ? e : swe;
            if (r_iteration != '1) r_iteration <= r_iteration + 1'b1;
            if (r_path_train && (r_train_cnt < c_train_max))
               r_train_cnt <= r_train_cnt + 1'b1;
         end

         if (w_overrun_set)    r_overrun <= 1'b1;
         else if (clear_flags) r_overrun <= 1'b0;

         if (w_timeout_set)    r_timeout <= 1'b1;
         else if (clear_flags) r_timeout <= 1'b0;
      end
   end

   assign conv_start   = r_entry && (r_state == ST_CONV);
   assign adapt_start  = r_entry && (r_state == ST_ADAPT);
   assign cancel_start = r_entry && (r_state == ST_CANCEL);
   assign out_start    = (r_state == ST_OUTPUT);
   assign out_double   = r_out_double;
   assign busy         = (r_state != ST_IDLE);
   assign training     = w_train_sel;
   assign iteration    = r_iteration;
   assign overrun      = r_overrun;
   assign timeout      = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_echo_cancel_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_echo_cancel_seq
// Purpose  : Directed self-checking bench for echo_cancel_seq.
// Revision : 1.0
// ============================================================================
module tb_echo_cancel_seq;

   logic        clk_operation = 1'b0;
   logic        rst;
   logic        enable;
   logic [12:0] sampling_cycle_counter;
   logic [1:0]  mode;
   logic        conv_start, adapt_start, cancel_start, out_start;
   logic        conv_ready, adapt_ready, cancel_ready;
   logic [63:0] e, swe, out_double;
   logic        training, busy, overrun, timeout, clear_flags;
   logic [3:0]  iteration;

   int n_checks = 0;
   int n_errors = 0;
   int n_conv   = 0;
   int n_out    = 0;
   int n_c0, n_o0, exp_iter;

   always #5 clk_operation = ~clk_operation;

   echo_cancel_seq #(
      .CNT_W         (13),
      .DATA_W        (64),
      .ITER_W        (4),
      .TRAIN_SAMPLES (3),
      .TIMEOUT       (10)
   ) dut (
      .clk_operation          (clk_operation),
      .rst                    (rst),
      .enable                 (enable),
      .sampling_cycle_counter (sampling_cycle_counter),
      .mode                   (mode),
      .conv_start             (conv_start),
      .conv_ready             (conv_ready),
      .adapt_start            (adapt_start),
      .adapt_ready            (adapt_ready),
      .cancel_start           (cancel_start),
      .cancel_ready           (cancel_ready),
      .e                      (e),
      .swe                    (swe),
      .out_double             (out_double),
      .out_start              (out_start),
      .training               (training),
      .iteration              (iteration),
      .busy                   (busy),
      .overrun                (overrun),
      .timeout                (timeout),
      .clear_flags            (clear_flags)
   );

   always @(negedge clk_operation) begin
      if (conv_start) n_conv++;
      if (out_start)  n_out++;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_operation);
      #1;
   endtask

   task automatic send_tick();
      sampling_cycle_counter = 13'd0;
      step();
      sampling_cycle_counter = 13'd1;
   endtask

   // Entered one cycle after the tick; lat counts cycles since the tick.
   task automatic wait_out(input string tag, input int exp_lat);
      int lat;
      lat = 1;
      while (!out_start && lat < 30) begin
         step();
         lat++;
      end
      check({tag, "_lat"}, lat, exp_lat);
   endtask

   task automatic run_sample(input string tag, input int exp_lat, input logic [63:0] exp_data);
      send_tick();
      wait_out(tag, exp_lat);
      check({tag, "_data"}, out_double, exp_data);
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      rst = 1'b0; enable = 1'b0; sampling_cycle_counter = 13'd1; mode = 2'b00;
      conv_ready = 1'b1; adapt_ready = 1'b1; cancel_ready = 1'b1; clear_flags = 1'b0;
      e = 64'h0; swe = 64'h0;
      #23;
      check("rst_busy", busy, 0);
      check("rst_starts", {conv_start, adapt_start, cancel_start, out_start}, 0);
      check("rst_out_double", out_double, 0);
      check("rst_iteration", iteration, 0);
      check("rst_flags", {overrun, timeout}, 0);
      #4 rst = 1'b1;
      #1 check("rst_training", training, 1);
      step();
      enable = 1'b1;

      // Auto mode: three training samples, then cancel-only.
      for (int k = 0; k < 3; k++) begin
         e   = 64'h4000_0000_0000_0000 | 64'(k);
         swe = 64'hC000_0000_0000_0000 | 64'(k);
         run_sample($sformatf("train%0d", k), 7, 64'h4000_0000_0000_0000 | 64'(k));
         check($sformatf("training_after%0d", k), training, (k < 2) ? 1 : 0);
      end
      e = 64'h1111; swe = 64'h3FF8_0000_0000_0000;
      run_sample("auto_cancel", 5, 64'h3FF8_0000_0000_0000);
      check("iter_after4", iteration, 4);

      // Cancel engine never answers: watchdog fires 10 cycles after entry.
      cancel_ready = 1'b0;
      n_o0 = n_out;
      send_tick();
      step();
      step();
      check("to_cancel_start", cancel_start, 1);
      repeat (9) step();
      check("to_not_yet", timeout, 0);
      step();
      check("to_set", timeout, 1);
      check("to_idle", busy, 0);
      check("to_no_out", n_out - n_o0, 0);
      check("to_iter", iteration, 4);
      clear_flags = 1'b1;
      step();
      clear_flags = 1'b0;
      check("to_cleared", timeout, 0);
      cancel_ready = 1'b1;

      // Second tick arrives while adaptation is pending.
      mode = 2'b01; adapt_ready = 1'b0;
      e = 64'h4010_0000_0000_0005; swe = 64'h5;
      n_o0 = n_out; n_c0 = n_conv;
      send_tick();
      step();
      step();
      check("ovr_adapt_start", adapt_start, 1);
      send_tick();
      check("ovr_set", overrun, 1);
      adapt_ready = 1'b1;
      wait_out("ovr", 4);
      check("ovr_data", out_double, 64'h4010_0000_0000_0005);
      repeat (10) step();
      check("ovr_one_out", n_out - n_o0, 1);
      check("ovr_one_conv", n_conv - n_c0, 1);
      check("ovr_sticky", overrun, 1);
      check("ovr_iter", iteration, 5);
      clear_flags = 1'b1;
      step();
      clear_flags = 1'b0;
      check("ovr_cleared", overrun, 0);

      // Reset asserted in the middle of CANCEL.
      mode = 2'b10; cancel_ready = 1'b0;
      send_tick();
      step();
      step();
      check("mrst_in_cancel", cancel_start, 1);
      n_o0 = n_out;
      #2 rst = 1'b0;
      #1;
      check("mrst_busy", busy, 0);
      check("mrst_starts", {conv_start, adapt_start, cancel_start, out_start}, 0);
      check("mrst_iter", iteration, 0);
      check("mrst_out_double", out_double, 0);
      @(negedge clk_operation);
      #2 rst = 1'b1;
      cancel_ready = 1'b1;
      step();
      check("mrst_no_out", n_out - n_o0, 0);
      check("mrst_training_m10", training, 0);
      mode = 2'b00;
      #1 check("mrst_training_m00", training, 1);

      // Freeze ignores ticks.
      mode = 2'b11; n_c0 = n_conv;
      send_tick();
      repeat (3) step();
      send_tick();
      repeat (3) step();
      check("frz_no_conv", n_conv - n_c0, 0);
      check("frz_idle", busy, 0);
      check("frz_no_ovr", overrun, 0);

      // Forced cancel with no training done yet.
      mode = 2'b10; e = 64'hAAAA; swe = 64'h4020_0000_0000_0001;
      run_sample("force_cancel", 5, 64'h4020_0000_0000_0001);
      check("fc_iter", iteration, 1);
      mode = 2'b00;
      #1 check("fc_training", training, 1);
      e = 64'h4030_0000_0000_0002; swe = 64'hBBBB;
      run_sample("train_after_rst", 7, 64'h4030_0000_0000_0002);
      check("tar_iter", iteration, 2);

      // Counter parked at zero yields a single tick.
      mode = 2'b10; n_c0 = n_conv; n_o0 = n_out;
      sampling_cycle_counter = 13'd0;
      repeat (5) step();
      sampling_cycle_counter = 13'd1;
      repeat (8) step();
      check("hold_one_conv", n_conv - n_c0, 1);
      check("hold_one_out", n_out - n_o0, 1);
      check("hold_no_ovr", overrun, 0);
      check("hold_iter", iteration, 3);

      // Iteration saturates at all-ones.
      exp_iter = 3;
      swe = 64'h7777;
      while (exp_iter < 15) begin
         run_sample("sat_fill", 5, 64'h7777);
         exp_iter++;
      end
      check("sat_full", iteration, 15);
      run_sample("sat_extra", 5, 64'h7777);
      check("sat_hold", iteration, 15);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
